// File: rtl/ssd_message_scroller_if.sv
// Character write channel between the upstream writer and ssd_message_scroller.
//   wr_valid : writer offers a character on wr_char
//   wr_char  : 5-bit character code
//   wr_ready : scroller can accept a character this cycle
// master = writer side, slave = scroller side.
interface ssd_message_scroller_if;
  logic       wr_valid;
  logic [4:0] wr_char;
  logic       wr_ready;

  modport master (output wr_valid, output wr_char, input wr_ready);
  modport slave  (input wr_valid, input wr_char, output wr_ready);
endinterface

// File: rtl/ssd_message_scroller.sv
// Six-digit seven-segment message scroller.
// Holds up to 16 character codes; messages longer than six characters scroll left by one
// position every TICK_DIV clock cycles while en is high. Segment outputs are registered and
// active-low, bits 0..6 = segments a..g, display0 is the leftmost digit.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous clear of the message (drops a same-cycle write)
//   en                  : scroll enable
//   wr                  : write channel (ssd_message_scroller_if.slave)
//   len_o               : current message length 0..16
//   display0..5_Output  : segment buses
// Optional feature: define SSD_SCROLL_GAP_EN to insert one blank position between the last
// and first character when the message wraps.
module ssd_message_scroller #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  ssd_message_scroller_if.slave        wr,
  output logic [4:0]                   len_o,
  output logic [0:6]                   display0_Output,
  output logic [0:6]                   display1_Output,
  output logic [0:6]                   display2_Output,
  output logic [0:6]                   display3_Output,
  output logic [0:6]                   display4_Output,
  output logic [0:6]                   display5_Output
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TermCnt = PW'(TICK_DIV - 1);
  localparam logic [0:6] Blank = 7'b1111111;

  logic [4:0]    buf_q [16];
  logic [4:0]    len_q, len_d;
  logic [4:0]    start_q, start_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [0:6]    disp_q [6];
  logic [0:6]    disp_d [6];
  logic [4:0]    eff_len;
  logic          wr_fire;

  function automatic logic [0:6] seg_enc(input logic [4:0] code);
    logic [0:6] s;
    case (code)
      5'd0:    s = 7'b0000001;
      5'd1:    s = 7'b1001111;
      5'd2:    s = 7'b0010010;
      5'd3:    s = 7'b0000110;
      5'd4:    s = 7'b1001100;
      5'd5:    s = 7'b0100100;
      5'd6:    s = 7'b0100000;
      5'd7:    s = 7'b0001111;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0000100;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b1100000;
      5'd12:   s = 7'b0110001;
      5'd13:   s = 7'b1000010;
      5'd14:   s = 7'b0110000;
      5'd15:   s = 7'b0111000;
      5'd16:   s = 7'b1001000;
      5'd17:   s = 7'b1110001;
      5'd18:   s = 7'b0011000;
      5'd19:   s = 7'b1111010;
      5'd20:   s = 7'b1000001;
      5'd21:   s = 7'b1101010;
      5'd22:   s = 7'b1100001;
      5'd23:   s = 7'b1000011;
      5'd24:   s = 7'b1000100;
      5'd25:   s = 7'b1111110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef SSD_SCROLL_GAP_EN
  assign eff_len = len_q + 5'd1;
`else
  assign eff_len = len_q;
`endif

  assign wr.wr_ready = (len_q != 5'd16) && !clr;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign len_o       = len_q;

  // Buffer contents past len are don't-care, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      buf_q[len_q[3:0]] <= wr.wr_char;
    end
  end

  always_comb begin
    len_d   = len_q;
    start_d = start_q;
    presc_d = presc_q;
    if (clr) begin
      len_d   = 5'd0;
      start_d = 5'd0;
      presc_d = '0;
    end else begin
      if (wr_fire) begin
        len_d = len_q + 5'd1;
      end
      if (len_q <= 5'd6) begin
        start_d = 5'd0;
        presc_d = '0;
      end else if (en) begin
        if (presc_q == TermCnt) begin
          presc_d = '0;
          start_d = (start_q + 5'd1 == eff_len) ? 5'd0 : start_q + 5'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    end
  end

  // Window decode: start < L and i < 6, so one conditional subtraction wraps the index.
  always_comb begin
    logic [4:0] idx;
    for (int i = 0; i < 6; i++) begin
      idx = start_q + 5'(i);
      if (idx >= eff_len) begin
        idx = idx - eff_len;
      end
      if (len_q == 5'd0 || (len_q <= 5'd6 && 5'(i) >= len_q) || idx == len_q) begin
        disp_d[i] = Blank;
      end else begin
        disp_d[i] = seg_enc(buf_q[idx[3:0]]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= 5'd0;
      start_q <= 5'd0;
      presc_q <= '0;
      for (int i = 0; i < 6; i++) begin
        disp_q[i] <= Blank;
      end
    end else begin
      len_q   <= len_d;
      start_q <= start_d;
      presc_q <= presc_d;
      for (int i = 0; i < 6; i++) begin
        disp_q[i] <= disp_d[i];
      end
    end
  end

  assign display0_Output = disp_q[0];
  assign display1_Output = disp_q[1];
  assign display2_Output = disp_q[2];
  assign display3_Output = disp_q[3];
  assign display4_Output = disp_q[4];
  assign display5_Output = disp_q[5];

endmodule

// File: doc/ssd_message_scroller.md
# ssd_message_scroller

Drives the six seven-segment displays (display0 leftmost) from a writable message buffer of up to 16 character codes. Long messages scroll left across the display window one position per prescaler tick. It replaces the fixed two-word toggle stage: one upstream writer loads characters, and the segment buses connect directly to the display pins. The block contains the message buffer, the scroll prescaler, the window pointer and the character-to-segment encoder.

## Interface

- TICK_DIV, 25_000_000 — clk cycles per scroll step; must be ≥ 2.
- clk  in  1  main clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  one-cycle pulse; empties the buffer.
- wr_valid  in  1  a character is offered on wr_char.
- wr_char  in  5  character code (encoding listed below).
- wr_ready  out  1  buffer can accept a character; equals (len != 16) && !clr.
- en  in  1  scroll enable.
- len_o  out  5  current message length, 0..16.
- display0_Output … display5_Output  out  [0:6] each  segments a..g in bit order 0..6; active-low (0 = lit).

## Operation

- **Reset** (rst_n low, asynchronous):
  - len = 0, start = 0, prescaler = 0.
  - All displays = 1111111.
  - wr_ready = 1.
- **Write:** when wr_valid && wr_ready on a rising edge:
  - buf[len] <= wr_char.
  - len <= len + 1.
- **Clear:** when clr is high:
  - len, start and prescaler all go to 0.
  - A write offered in the same cycle is dropped, because wr_ready is low.
- **Effective length:** L = len, or len + 1 when the gap option is enabled (see Configuration).
- **Scrolling:**
  - The block scrolls only when en = 1 and len > 6.
  - The prescaler counts 0..TICK_DIV-1.
  - At the terminal count the prescaler returns to 0 and start <= (start + 1 == L) ? 0 : start + 1.
  - en = 0 freezes both the prescaler and start.
  - When len ≤ 6, start and the prescaler are held at 0.
- **Window index for display i:** idx = start + i; if idx ≥ L, subtract L once. Because start < L and i < 6, a single subtraction is enough.
- **What display i shows:**
  - Blank if len == 0.
  - Blank if len ≤ 6 and i ≥ len.
  - Blank if idx == len (the gap position).
  - Otherwise seg(buf[idx]).
- **Writes during scrolling** are legal. The new L takes effect immediately, and start is unaffected.
- **Encoding** (code: a..g):
  - Digits:
    - 0: 0000001
    - 1: 1001111
    - 2: 0010010
    - 3: 0000110
    - 4: 1001100
    - 5: 0100100
    - 6: 0100000
    - 7: 0001111
    - 8: 0000000
    - 9: 0000100
  - Letters:
    - 10 A: 0001000
    - 11 b: 1100000
    - 12 C: 0110001
    - 13 d: 1000010
    - 14 E: 0110000
    - 15 F: 0111000
    - 16 H: 1001000
    - 17 L: 1110001
    - 18 P: 0011000
    - 19 r: 1111010
    - 20 U: 1000001
    - 21 n: 1101010
    - 24 y: 1000100
  - W halves: 22 W-left: 1100001; 23 W-right: 1000011.
  - Punctuation: 25 '-': 1111110.
  - 26–31: blank, 1111111.

## Timing

- Display outputs are registered and are computed from the state (buf, len, start) as it stands before the edge.
- A write accepted at edge N shows on the displays after edge N+1.
- A scroll step at edge N shows on the displays after edge N+1.
- clr at edge N: displays are blank after edge N+1.
- wr_ready is combinational: it drops in the same cycle that clr is asserted.
- wr_ready drops after the edge on which len reaches 16.
- First scroll step: TICK_DIV cycles after en rises, given len > 6.
- Steady-state scroll rate: exactly TICK_DIV cycles per step.
- Reset asserted mid-scroll: outputs go blank immediately (asynchronously). After release, the buffer is empty.

## Configuration

- Macro: SSD_SCROLL_GAP_EN.
- **Defined:** one blank position is inserted between the last character and the wrap to the first.
  - L = len + 1.
  - start cycles through 0..len.
- **Undefined:** the message wraps directly, last character then first.
  - L = len.
  - start cycles through 0..len-1.
- The no-scroll behaviour for len ≤ 6 is the same in both modes.

## Test plan

All directed scenarios use TICK_DIV = 4, macro undefined unless stated.

- **Reset:** apply reset, release → all displays 1111111, wr_ready = 1, len_o = 0.
- **Static HELLO:** write codes 16, 14, 17, 17, 0 with en = 1 → displays 1001000, 0110000, 1110001, 1110001, 0000001, 1111111; no change over 100 cycles.
- **Scroll and wrap:** write codes 1–7, then set en = 1.
  - 4 cycles later display0 = 0010010 (digit 2).
  - After 7 steps display0 = 1001111 (digit 1) again.
  - With the macro defined: after step 6, display0 = 0001111 (digit 7) and display1 is blank.
- **Full buffer:** 16 back-to-back writes → wr_ready = 0, len_o = 16. A 17th wr_valid is ignored and len_o stays 16.
- **Clear with write:** assert clr and wr_valid in the same cycle → write dropped, len_o = 0, all displays 1111111 one cycle later.
- **Async reset mid-scroll:** pulse rst_n low between edges → displays blank immediately, without waiting for an edge; start = 0 and len_o = 0 after release.
